// File: rtl/matrix_pe.sv
// Integer dot-product PE: per uop, consumes N paired neuron/weight beats of
// signed int16 lanes and emits the wrapped 32-bit accumulated sum with a one-cycle vld_o.
module matrix_pe #(
    parameter int LANES = 32,
    parameter int DW    = 16,
    parameter int AW    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES*DW-1:0]   nram_mpe_neuron,
    input  logic                  nram_mpe_neuron_valid,
    output logic                  nram_mpe_neuron_ready,
    input  logic [LANES*DW-1:0]   wram_mpe_weight,
    input  logic                  wram_mpe_weight_valid,
    output logic                  wram_mpe_weight_ready,
    input  logic [7:0]            ib_ctl_uop,
    input  logic                  ib_ctl_uop_valid,
    output logic                  ib_ctl_uop_ready,
    output logic [AW-1:0]         result,
    output logic                  vld_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          count;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       dot;
    logic signed [2*DW-1:0] prod;
    logic                armed;
    logic                uop_fire;
    logic                pair_fire;

    assign uop_fire  = ib_ctl_uop_valid && ib_ctl_uop_ready;
    assign pair_fire = nram_mpe_neuron_valid && nram_mpe_neuron_ready &&
                       wram_mpe_weight_valid && wram_mpe_weight_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (uop_fire) state_nxt = (ib_ctl_uop == 8'd0) ? DONE : RUN;
            RUN:  if (pair_fire && count == 8'd1) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // armed keeps uop_ready low for the cycle following a sampled reset
    always_comb begin
        ib_ctl_uop_ready      = 1'b0;
        nram_mpe_neuron_ready = 1'b0;
        wram_mpe_weight_ready = 1'b0;
        case (state)
            IDLE: ib_ctl_uop_ready = armed;
            RUN: begin
                nram_mpe_neuron_ready = nram_mpe_neuron_valid && wram_mpe_weight_valid;
                wram_mpe_weight_ready = nram_mpe_neuron_valid && wram_mpe_weight_valid;
            end
            default: ;
        endcase
    end

    // Single-cycle lane-wise multiply and adder tree, all sums wrap modulo 2^AW
    always_comb begin
        dot  = '0;
        prod = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            prod = $signed(nram_mpe_neuron[DW*i +: DW]) * $signed(wram_mpe_weight[DW*i +: DW]);
            dot  = dot + AW'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            acc    <= '0;
            result <= '0;
            vld_o  <= 1'b0;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            vld_o <= (state == DONE);
            if (uop_fire) begin
                count <= ib_ctl_uop;
                acc   <= '0;
            end else if (pair_fire) begin
                count <= count - 8'd1;
                acc   <= acc + dot;
            end
            if (state == DONE) begin
                result <= acc;
            end
        end
    end

endmodule

// File: tb/tb_matrix_pe.sv
// Self-checking bench for matrix_pe: directed steps feed a result scoreboard
// that a vld_o monitor pops and compares against an int16 dot-product model.
module tb_matrix_pe;

    localparam int LANES = 32;
    localparam int DW    = 16;
    localparam int AW    = 32;
    localparam int BW    = LANES * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] neuron = '0;
    logic [BW-1:0] weight = '0;
    logic          neuron_valid = 1'b0;
    logic          weight_valid = 1'b0;
    logic [7:0]    uop = '0;
    logic          uop_valid = 1'b0;
    logic          neuron_ready;
    logic          weight_ready;
    logic          uop_ready;
    logic [AW-1:0] result;
    logic          vld;

    int vectors = 0;
    int miscompares = 0;
    int n_xfers = 0;
    int w_xfers = 0;
    int split = 0;
    int pulses = 0;
    logic uf, nf, wf;

    logic [AW-1:0] exp_q[$];
    int            plan_n[$];
    logic [AW-1:0] plan_exp[$];
    logic [BW-1:0] nbeats[$];
    logic [BW-1:0] wbeats[$];

    matrix_pe #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .nram_mpe_neuron       (neuron),
        .nram_mpe_neuron_valid (neuron_valid),
        .nram_mpe_neuron_ready (neuron_ready),
        .wram_mpe_weight       (weight),
        .wram_mpe_weight_valid (weight_valid),
        .wram_mpe_weight_ready (weight_ready),
        .ib_ctl_uop            (uop),
        .ib_ctl_uop_valid      (uop_valid),
        .ib_ctl_uop_ready      (uop_ready),
        .result                (result),
        .vld_o                 (vld)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        assert (got === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    function automatic logic [AW-1:0] golden(input logic [BW-1:0] n, input logic [BW-1:0] w);
        int s = 0;
        shortint a, b;
        for (int i = 0; i < LANES; i++) begin
            a = n[DW*i +: DW];
            b = w[DW*i +: DW];
            s += a * b;
        end
        return s;
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < BW/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic void plan_uop(input int n, input bit rnd, input logic [BW-1:0] nfix,
                                     input logic [BW-1:0] wfix, input bit use_exp,
                                     input logic [AW-1:0] expv);
        logic [AW-1:0] e = '0;
        logic [BW-1:0] nb, wb;
        for (int k = 0; k < n; k++) begin
            nb = rnd ? rand_beat() : nfix;
            wb = rnd ? rand_beat() : wfix;
            nbeats.push_back(nb);
            wbeats.push_back(wb);
            e = e + golden(nb, wb);
        end
        plan_n.push_back(n);
        plan_exp.push_back(use_exp ? expv : e);
    endfunction

    // Inputs are set at the negedge; sample handshakes, cross the posedge, return at next negedge
    task automatic tick();
        #1;
        uf = uop_valid && uop_ready;
        nf = neuron_valid && neuron_ready;
        wf = weight_valid && weight_ready;
        if (nf) n_xfers++;
        if (wf) w_xfers++;
        if (nf != wf) split++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_plan(input int drop, input int budget);
        int ui = 0, ni = 0, wi = 0, cyc = 0;
        while ((ui < plan_n.size() || ni < nbeats.size() || wi < wbeats.size() ||
                exp_q.size() != 0) && cyc < budget) begin
            uop_valid    = (ui < plan_n.size()) && ($urandom_range(99) >= drop);
            uop          = (ui < plan_n.size()) ? 8'(plan_n[ui]) : 8'd0;
            neuron_valid = (ni < nbeats.size()) && ($urandom_range(99) >= drop);
            neuron       = (ni < nbeats.size()) ? nbeats[ni] : '0;
            weight_valid = (wi < wbeats.size()) && ($urandom_range(99) >= drop);
            weight       = (wi < wbeats.size()) ? wbeats[wi] : '0;
            tick();
            if (uf) begin
                exp_q.push_back(plan_exp[ui]);
                ui++;
            end
            if (nf) ni++;
            if (wf) wi++;
            cyc++;
        end
        uop_valid = 1'b0;
        neuron_valid = 1'b0;
        weight_valid = 1'b0;
        check("plan_complete", 32'(cyc < budget), 32'd1);
        plan_n.delete();
        plan_exp.delete();
        nbeats.delete();
        wbeats.delete();
    endtask

    task automatic issue_uop(input int n, input bit push, input logic [AW-1:0] expv);
        bit got = 0;
        uop = 8'(n);
        uop_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (uf) begin
                got = 1;
                break;
            end
        end
        uop_valid = 1'b0;
        check("uop_accept", 32'(got), 32'd1);
        if (got && push) exp_q.push_back(expv);
    endtask

    task automatic wait_pair();
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (nf && wf) begin
                got = 1;
                break;
            end
        end
        check("pair_accept", 32'(got), 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        tick();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && vld) begin
            pulses++;
            check("vld_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("result", result, exp_q.pop_front());
        end
    end

    initial begin
        logic [BW-1:0] an, aw, bn, bw;
        int x0, w0, p0, bad, lat;

        repeat (3) @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_vld", 32'(vld), 32'd0);
        check("rst_uop_ready", 32'(uop_ready), 32'd0);
        check("rst_data_ready", 32'(neuron_ready || weight_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // N=1, 1 x 2 in every lane
        plan_uop(1, 0, {32{16'h0001}}, {32{16'h0002}}, 1, 32'h0000_0040);
        run_plan(0, 100);

        // N=3, -1 x 3 in every lane
        x0 = n_xfers;
        plan_uop(3, 0, {32{16'hFFFF}}, {32{16'h0003}}, 1, 32'hFFFF_FEE0);
        run_plan(0, 100);
        check("n3_xfers", 32'(n_xfers - x0), 32'd3);

        // Four uops, N summing to 140, random valid toggling on every channel
        x0 = n_xfers; w0 = w_xfers; p0 = pulses; split = 0;
        plan_uop(50, 1, '0, '0, 0, '0);
        plan_uop(30, 1, '0, '0, 0, '0);
        plan_uop(40, 1, '0, '0, 0, '0);
        plan_uop(20, 1, '0, '0, 0, '0);
        run_plan(35, 3000);
        check("rand_n_xfers", 32'(n_xfers - x0), 32'd140);
        check("rand_w_xfers", 32'(w_xfers - w0), 32'd140);
        check("rand_split", 32'(split), 32'd0);
        check("rand_pulses", 32'(pulses - p0), 32'd4);

        // Neuron-only stall for 20 cycles between two real pairs
        an = rand_beat(); aw = rand_beat(); bn = rand_beat(); bw = rand_beat();
        issue_uop(2, 1, golden(an, aw) + golden(bn, bw));
        neuron = an; weight = aw; neuron_valid = 1'b1; weight_valid = 1'b1;
        wait_pair();
        neuron = bn; weight = bw; weight_valid = 1'b0;
        x0 = n_xfers; bad = 0;
        repeat (20) begin
            tick();
            if (neuron_ready || weight_ready) bad++;
        end
        check("stall_ready", 32'(bad), 32'd0);
        check("stall_xfer", 32'(n_xfers - x0), 32'd0);
        weight_valid = 1'b1;
        wait_pair();
        neuron_valid = 1'b0; weight_valid = 1'b0;
        drain(50);

        // N=0 with data offered: no consumption, vld two cycles after acceptance
        neuron = rand_beat(); weight = rand_beat();
        neuron_valid = 1'b1; weight_valid = 1'b1;
        x0 = n_xfers; lat = 0;
        issue_uop(0, 1, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (vld) begin
                lat = i + 1;
                break;
            end
        end
        neuron_valid = 1'b0; weight_valid = 1'b0;
        check("n0_latency", 32'(lat), 32'd2);
        check("n0_xfers", 32'(n_xfers - x0), 32'd0);
        drain(10);

        // Reset partway through N=10, then a single saturating-magnitude beat
        issue_uop(10, 0, '0);
        neuron_valid = 1'b1; weight_valid = 1'b1;
        repeat (4) begin
            neuron = rand_beat(); weight = rand_beat();
            tick();
        end
        rst_n = 1'b0;
        tick();
        tick();
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_vld", 32'(vld), 32'd0);
        check("mid_rst_ready", 32'(uop_ready || neuron_ready || weight_ready), 32'd0);
        neuron_valid = 1'b0; weight_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        p0 = pulses;
        plan_uop(1, 0, {32{16'h7FFF}}, {32{16'h7FFF}}, 1, 32'hFFE0_0020);
        run_plan(0, 100);
        check("post_rst_pulses", 32'(pulses - p0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
